// File: rtl/project_pwm_action_deadband_pkg.sv
// Shared encodings for the PWM action qualifier and dead-band generator.
// Event index order doubles as priority order: a higher index wins.
package project_pwm_action_deadband_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_UP      = 2'b01,
        MODE_DOWN    = 2'b10,
        MODE_UP_DOWN = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ACT_NONE   = 2'b00,
        ACT_CLEAR  = 2'b01,
        ACT_SET    = 2'b10,
        ACT_TOGGLE = 2'b11
    } action_e;

    typedef enum logic [1:0] {
        LOAD_ALWAYS  = 2'b00,
        LOAD_ZRO     = 2'b01,
        LOAD_PRD     = 2'b10,
        LOAD_ZRO_PRD = 2'b11
    } load_sel_e;

    typedef enum logic [1:0] {
        DB_H_ON       = 2'b00,
        DB_BOTH_OFF_R = 2'b01,
        DB_L_ON       = 2'b10,
        DB_BOTH_OFF_F = 2'b11
    } db_state_e;

    localparam int EV_ZRO   = 0;
    localparam int EV_PRD   = 1;
    localparam int EV_CAU   = 2;
    localparam int EV_CAD   = 3;
    localparam int EV_CBU   = 4;
    localparam int EV_CBD   = 5;
    localparam int NUM_EV   = 6;
    localparam int AQ_WIDTH = 2 * NUM_EV;

    // Later (higher-index) events overwrite earlier ones, giving CBD the top priority.
    function automatic action_e resolve_action(input logic [NUM_EV-1:0]   ev,
                                               input logic [AQ_WIDTH-1:0] aq);
        action_e act;
        act = ACT_NONE;
        for (int i = 0; i < NUM_EV; i++) begin
            if (ev[i] && (aq[2*i +: 2] != 2'b00)) begin
                act = action_e'(aq[2*i +: 2]);
            end
        end
        return act;
    endfunction

    function automatic logic apply_action(input action_e act, input logic cur);
        logic res;
        case (act)
            ACT_CLEAR:  res = 1'b0;
            ACT_SET:    res = 1'b1;
            ACT_TOGGLE: res = ~cur;
            default:    res = cur;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/project_pwm_deadband.sv
// Dead-band generator: splits one raw waveform into a non-overlapping high/low gate pair.
// Rising/falling edges appear after delay+1 cycles; force_off zeroes both outputs next cycle.
module project_pwm_deadband
    import project_pwm_action_deadband_pkg::*;
#(
    parameter int DT_WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                raw,
    input  logic                dt_en,
    input  logic [DT_WIDTH-1:0] dt_rise,
    input  logic [DT_WIDTH-1:0] dt_fall,
    input  logic                force_off,
    output logic                h,
    output logic                l
);

    db_state_e           state, next_state;
    logic [DT_WIDTH-1:0] cnt, next_cnt;
    logic                next_h, next_l;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= DB_BOTH_OFF_F;
            cnt   <= '0;
            h     <= 1'b0;
            l     <= 1'b0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            h     <= next_h;
            l     <= next_l;
        end
    end

    // cnt counts the cycles raw has held its level, the edge cycle included.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        next_h     = h;
        next_l     = l;
        if (force_off) begin
            next_state = raw ? DB_BOTH_OFF_R : DB_BOTH_OFF_F;
            next_cnt   = '0;
            next_h     = 1'b0;
            next_l     = 1'b0;
        end else if (!dt_en) begin
            next_state = raw ? DB_H_ON : DB_L_ON;
            next_cnt   = '0;
            next_h     = raw;
            next_l     = ~raw;
        end else if (raw) begin
            next_l = 1'b0;
            case (state)
                DB_H_ON: next_h = 1'b1;
                DB_BOTH_OFF_R: begin
                    if (cnt >= dt_rise) begin
                        next_state = DB_H_ON;
                        next_cnt   = '0;
                        next_h     = 1'b1;
                    end else begin
                        next_cnt = cnt + DT_WIDTH'(1);
                        next_h   = 1'b0;
                    end
                end
                default: begin
                    if (dt_rise == '0) begin
                        next_state = DB_H_ON;
                        next_cnt   = '0;
                        next_h     = 1'b1;
                    end else begin
                        next_state = DB_BOTH_OFF_R;
                        next_cnt   = DT_WIDTH'(1);
                        next_h     = 1'b0;
                    end
                end
            endcase
        end else begin
            next_h = 1'b0;
            case (state)
                DB_L_ON: next_l = 1'b1;
                DB_BOTH_OFF_F: begin
                    if (cnt >= dt_fall) begin
                        next_state = DB_L_ON;
                        next_cnt   = '0;
                        next_l     = 1'b1;
                    end else begin
                        next_cnt = cnt + DT_WIDTH'(1);
                        next_l   = 1'b0;
                    end
                end
                default: begin
                    if (dt_fall == '0) begin
                        next_state = DB_L_ON;
                        next_cnt   = '0;
                        next_l     = 1'b1;
                    end else begin
                        next_state = DB_BOTH_OFF_F;
                        next_cnt   = DT_WIDTH'(1);
                        next_l     = 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/project_pwm_action_deadband.sv
// PWM event detection, action qualifier, compare shadow load and trip latch feeding a dead-band pair.
// Raw A/B land one cycle after the event; gates follow raw A one or more cycles later; no flow control.
module project_pwm_action_deadband
    import project_pwm_action_deadband_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int DT_WIDTH = 8
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_cnt_en,
    input  logic [1:0]          i_mode,
    input  logic [WIDTH-1:0]    i_counter,
    input  logic [WIDTH-1:0]    i_counter_next,
    input  logic [WIDTH-1:0]    i_period,
    input  logic [WIDTH-1:0]    i_compare_a,
    input  logic [WIDTH-1:0]    i_compare_b,
    input  logic [1:0]          i_load_sel,
    input  logic [11:0]         i_aq_a,
    input  logic [11:0]         i_aq_b,
    input  logic                i_dt_en,
    input  logic [DT_WIDTH-1:0] i_dt_rise,
    input  logic [DT_WIDTH-1:0] i_dt_fall,
    input  logic                i_trip,
    output logic                o_pwm_h,
    output logic                o_pwm_l,
    output logic                o_pwm_b,
    output logic                o_tripped
);

    mode_e              mode;
    logic               qual;
    logic               count_up;
    logic [NUM_EV-1:0]  ev;
    logic               load;
    logic [WIDTH-1:0]   active_a, active_b;
    logic               raw_a, raw_b;
    logic               tripped;
    logic               force_off;

    assign mode = mode_e'(i_mode);

    always_comb begin
        count_up = 1'b0;
        ev       = '0;
        load     = 1'b0;
        // A stalled or stopped counter must not re-fire the event it is parked on.
        qual = i_cnt_en && (mode != MODE_OFF);
        case (mode)
            MODE_UP:   count_up = 1'b1;
            MODE_DOWN: count_up = 1'b0;
            default:   count_up = i_counter_next > i_counter;
        endcase
        ev[EV_ZRO] = qual && (i_counter == '0);
        ev[EV_PRD] = qual && (i_counter == i_period);
        ev[EV_CAU] = qual &&  count_up && (i_counter == active_a) && (active_a <= i_period);
        ev[EV_CAD] = qual && !count_up && (i_counter == active_a) && (active_a <= i_period);
        ev[EV_CBU] = qual &&  count_up && (i_counter == active_b) && (active_b <= i_period);
        ev[EV_CBD] = qual && !count_up && (i_counter == active_b) && (active_b <= i_period);
        case (i_load_sel)
            LOAD_ALWAYS: load = 1'b1;
            LOAD_ZRO:    load = ev[EV_ZRO];
            LOAD_PRD:    load = ev[EV_PRD];
            default:     load = ev[EV_ZRO] | ev[EV_PRD];
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            raw_a    <= 1'b0;
            raw_b    <= 1'b0;
            active_a <= '0;
            active_b <= '0;
            tripped  <= 1'b0;
        end else begin
            raw_a <= apply_action(resolve_action(ev, i_aq_a), raw_a);
            raw_b <= apply_action(resolve_action(ev, i_aq_b), raw_b);
            if (load) begin
                active_a <= i_compare_a;
                active_b <= i_compare_b;
            end
            if (i_trip) begin
                tripped <= 1'b1;
            end else if (ev[EV_ZRO]) begin
                tripped <= 1'b0;
            end
        end
    end

    // The latch bit itself still forces the clearing cycle, so the pair restarts from BOTH_OFF.
    assign force_off = i_trip | tripped;
    assign o_pwm_b   = raw_b & ~tripped;
    assign o_tripped = tripped;

    project_pwm_deadband #(
        .DT_WIDTH (DT_WIDTH)
    ) u_deadband (
        .clk       (i_clk),
        .reset     (i_reset),
        .raw       (raw_a),
        .dt_en     (i_dt_en),
        .dt_rise   (i_dt_rise),
        .dt_fall   (i_dt_fall),
        .force_off (force_off),
        .h         (o_pwm_h),
        .l         (o_pwm_l)
    );

endmodule

// File: doc/project_pwm_action_deadband.md
Name: project_pwm_action_deadband

Overview:
- Downstream consumer of the master period counter. Takes the counter value, its next value and the counting mode.
- Detects zero, period and compare-A/B events, each qualified by count direction.
- Applies a programmable action qualifier to build raw PWM waveforms A and B.
- Passes A through a dead-band generator to produce the complementary high-side/low-side gate pair, with a latched trip input.

Parameters:
- WIDTH, 16, counter/compare width
- DT_WIDTH, 8, dead-time counter width

Ports:
- i_clk  in  1  clock
- i_reset  in  1  reset, synchronous, active-high
- i_cnt_en  in  1  counter enable; same signal that drives the master count enable
- i_mode  in  2  counting mode: 00 OFF, 01 UP, 10 DOWN, 11 UP_DOWN
- i_counter  in  WIDTH  master counter register
- i_counter_next  in  WIDTH  master next counter value
- i_period  in  WIDTH  period value
- i_compare_a  in  WIDTH  shadow compare A
- i_compare_b  in  WIDTH  shadow compare B
- i_load_sel  in  2  active-compare load: 00 every cycle, 01 on ZERO, 10 on PERIOD, 11 on ZERO or PERIOD
- i_aq_a  in  12  action field for A, 2 bits per event {CBD,CBU,CAD,CAU,PRD,ZRO} MSB→LSB; action codes 00 none, 01 clear, 10 set, 11 toggle
- i_aq_b  in  12  same layout as i_aq_a, for B
- i_dt_en  in  1  dead-band enable
- i_dt_rise  in  DT_WIDTH  rising-edge delay, cycles
- i_dt_fall  in  DT_WIDTH  falling-edge delay, cycles
- i_trip  in  1  fault input
- o_pwm_h  out  1  high-side gate
- o_pwm_l  out  1  low-side gate
- o_pwm_b  out  1  raw B, no dead-band
- o_tripped  out  1  trip latch state

Behaviour:
- Reset: o_pwm_h, o_pwm_l, o_pwm_b, o_tripped = 0; raw A/B = 0; active compares = 0; dead-band in BOTH_OFF with counter 0.
- Direction:
  - UP = up; DOWN = down.
  - UP_DOWN: up if i_counter_next > i_counter, else down.
  - OFF, or i_cnt_en = 0: no events generated (a stalled counter must not re-fire events).
- Events (evaluated on i_counter when qualified):
  - ZRO: counter == 0.
  - PRD: counter == i_period.
  - CAU/CAD: counter == active_a with direction up/down.
  - CBU/CBD: same as CAU/CAD, against active_b.
- Simultaneous events: the highest-priority event with a non-none action wins. Priority CBD > CBU > CAD > CAU > PRD > ZRO.
- Raw A/B update registered: the action lands one cycle after the event value appears on i_counter.
- Shadow load:
  - Active compares copy i_compare_a/b at the selected event (or every cycle for 00).
  - The new value is used from the next cycle.
  - The event that triggers the load still compares against the old active value.
- Dead-band (i_dt_en = 1), states H_ON, BOTH_OFF_R, L_ON, BOTH_OFF_F:
  - Raw rising edge: o_pwm_l = 0 next cycle; o_pwm_h = 1 after i_dt_rise+1 cycles.
  - Raw falling edge: o_pwm_h = 0 next cycle; o_pwm_l = 1 after i_dt_fall+1 cycles.
  - Raw reverses before a delay expires: the pending edge is cancelled, both outputs stay 0, and the delay for the opposite edge restarts from 0.
  - Delay 0 gives 1-cycle latency.
  - o_pwm_h and o_pwm_l are never 1 simultaneously.
- i_dt_en = 0: o_pwm_h = raw A, o_pwm_l = ~raw A, both registered with 1-cycle latency. The dead-band counter is held at 0.
- Trip:
  - i_trip high → o_tripped = 1 and o_pwm_h/l/b = 0 next cycle, overriding everything.
  - The latch clears only on a ZRO event with i_trip low.
  - Outputs resume from the current raw state through the dead-band starting in BOTH_OFF.
  - Raw A/B keep updating while tripped.
- Reset mid-operation: all state returns to reset values next edge; in-flight delays are discarded.
- Compare values above i_period never fire CA/CB events; this is not an error.
- Comparisons are unsigned, WIDTH bits; no arithmetic beyond the DT_WIDTH delay counter.

Decomposition:
- Shared package holds:
  - mode encodings (OFF/UP/DOWN/UP_DOWN)
  - action codes
  - event bit indices and priority order
  - load-select encodings
  - dead-band state encoding
- One sub-module: project_pwm_deadband (raw in, dt_en/dt_rise/dt_fall/force_off in, h/l out). The top holds event detection, the action qualifier, shadow load and the trip latch.

Test Plan:
- UP, period 9, active_a 4, ZRO=set, CAU=clear, dt off → o_pwm_h high for counter 0..3 (4 cycles of 10), delayed 1 cycle; o_pwm_l complementary.
- UP_DOWN, period 10, compare_a 3, CAU=set, CAD=clear, dt_rise 2, dt_fall 3 → h rises 3 cycles after the up-crossing raw edge and l falls 1 cycle after it; l rises 4 cycles after the down-crossing raw edge; both 0 in the gaps.
- dt_rise 5, raw A high pulse of 3 cycles → h never asserts; l low for 3+1 cycles then returns high after dt_fall+1.
- load_sel 01, compare_a changes 4→7 mid-period → old value 4 used until the next ZRO, 7 from the following period.
- i_trip pulse at counter 5 → all outputs 0 next cycle, o_tripped held through PRD; cleared at the next ZRO with trip low.
- i_cnt_en low with counter parked at 0 and ZRO=toggle → raw A toggles once only; simultaneous CAU=set and ZRO=clear with compare_a 0 → raw A set (CAU wins).
